module_display_scheduler: RTL and testbench

// - Time-multiplexed scan controller for the 8-digit 7-segment display on the 10 MHz domain.
// - Takes the 32-bit 8-nibble display word from the sweep generator (or any nibble source);

---
 rtl/module_display_scheduler.sv | 151 +++++++++++++++
 tb/tb_module_display_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/module_display_scheduler.sv
// -----------------------------------------------------------------------------
// module_display_scheduler
//
// Time-multiplexed scan controller for an 8-digit, active-low 7-segment display
// running on the 10 MHz clock. Each digit slot lasts SCAN_DIV cycles. The first
// BLANK_CYC cycles of a slot keep every anode off to stop ghosting between
// digits. The display word is latched once per frame so that a digit never
// shows half of an old word and half of a new one. A separate prescaler
// produces the one-cycle step enable for the sweep generator. pause_i freezes
// only that prescaler.
//
// Ports
//   clk_10Mhz_i  in   1   system clock, rising edge
//   rst_i        in   1   asynchronous reset, active-high
//   pause_i      in   1   1 = hold the step prescaler
//   data_i       in   32  eight hex nibbles, nibble d drives digit d
//   step_en_o    out  1   one-cycle step pulse every STEP_DIV unpaused cycles
//   an_o         out  8   digit anodes, active-low, at most one low
//   seg_o        out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp_o         out  1   decimal point, active-low, always off
//   digit_idx_o  out  3   index of the current digit slot
// -----------------------------------------------------------------------------
module module_display_scheduler #(
  parameter int SCAN_DIV  = 10_000,
  parameter int BLANK_CYC = 16,
  parameter int STEP_DIV  = 5_000_000
) (
  input  logic        clk_10Mhz_i,
  input  logic        rst_i,
  input  logic        pause_i,
  input  logic [31:0] data_i,
  output logic        step_en_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [2:0]  digit_idx_o
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int STEP_W = $clog2(STEP_DIV);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state_q, state_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [2:0]          digit_q, digit_d;
  logic [31:0]         frame_q, frame_d;
  logic [7:0]          an_d;
  logic [6:0]          seg_d;
  logic [STEP_W-1:0]   step_cnt_q;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Next-state logic for the scan FSM and the registered display outputs.
  // The outputs are computed from the next state. This makes the anodes and
  // segments change on the same edge that enters BLANK or SHOW.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    frame_d    = frame_q;
    an_d       = 8'hFF;
    seg_d      = 7'h7F;

    // The frame is latched at the very start of the digit-0 slot.
    if (state_q == ST_BLANK && digit_q == 3'd0 && scan_cnt_q == '0) begin
      frame_d = data_i;
    end

    case (state_q)
      ST_BLANK: begin
        if (scan_cnt_q == SCAN_W'(BLANK_CYC - 1)) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          digit_d    = digit_q + 3'd1;
          state_d    = ST_BLANK;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (state_d == ST_SHOW) begin
      an_d  = ~(8'h01 << digit_d);
      seg_d = hex_to_seg(frame_d[{digit_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk_10Mhz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_BLANK;
      scan_cnt_q <= '0;
      digit_q    <= 3'd0;
      frame_q    <= 32'h0;
      an_o       <= 8'hFF;
      seg_o      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      an_o       <= an_d;
      seg_o      <= seg_d;
    end
  end

  // Step prescaler. A paused cycle does not advance the count. A terminal
  // count that arrives while paused waits until the next unpaused cycle.
  always_ff @(posedge clk_10Mhz_i or posedge rst_i) begin
    if (rst_i) begin
      step_cnt_q <= '0;
      step_en_o  <= 1'b0;
    end else if (pause_i) begin
      step_en_o  <= 1'b0;
    end else if (step_cnt_q == STEP_W'(STEP_DIV - 1)) begin
      step_cnt_q <= '0;
      step_en_o  <= 1'b1;
    end else begin
      step_cnt_q <= step_cnt_q + 1'b1;
      step_en_o  <= 1'b0;
    end
  end

  assign digit_idx_o = digit_q;
  assign dp_o        = 1'b1;

endmodule

// File: tb/tb_module_display_scheduler.sv
module tb_module_display_scheduler;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int STEP_DIV  = 4;
  localparam int FRAME     = 8 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic        clk_10Mhz_i = 1'b0;
  logic        rst_i       = 1'b1;
  logic        pause_i     = 1'b0;
  logic [31:0] data_i      = 32'h0;
  logic        step_en_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [2:0]  digit_idx_o;

  always #5 clk_10Mhz_i = ~clk_10Mhz_i;

  module_display_scheduler #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk_10Mhz_i(clk_10Mhz_i),
    .rst_i      (rst_i),
    .pause_i    (pause_i),
    .data_i     (data_i),
    .step_en_o  (step_en_o),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .digit_idx_o(digit_idx_o)
  );

  // ---------------- reference model ----------------
  // t: clock edges since reset release; n: unpaused edges since reset release.
  // The frame model holds the word sampled at edge 1 of each frame.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          t;
  int          n;
  logic [31:0] frame_m;
  logic        step_m;

  // Scoreboard entry: {an, seg, digit_idx, step_en}.
  logic [18:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
    end
  endtask

  task automatic push_expected();
    int p, d, w;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    p = t % FRAME;
    d = p / SCAN_DIV;
    w = p % SCAN_DIV;
    if (w >= BLANK_CYC) begin
      e_an  = ~(8'h01 << d);
      e_seg = seg_tab[(frame_m >> (4 * d)) & 32'hF];
    end else begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
    end
    exp_q.push_back({e_an, e_seg, 3'(d), step_m});
  endtask

  task automatic compare_all();
    logic [18:0] e;
    push_expected();
    e = exp_q.pop_front();
    check("an",        32'(an_o),        32'(e[18:11]));
    check("seg",       32'(seg_o),       32'(e[10:4]));
    check("digit_idx", 32'(digit_idx_o), 32'(e[3:1]));
    check("step_en",   32'(step_en_o),   32'(e[0]));
    check("dp",        32'(dp_o),        32'd1);
    check("an_onehot", 32'($countones(~an_o) <= 1), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    @(posedge clk_10Mhz_i);
    t++;
    if (((t - 1) % FRAME) == 0) frame_m = data_i;
    if (!pause_i) n++;
    step_m = !pause_i && (n % STEP_DIV == 0);
    #1;
    compare_all();
    @(negedge clk_10Mhz_i);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Asserts reset between edges and checks that the outputs blank without a clock edge.
  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1;
    check("rst_an",    32'(an_o),        32'hFF);
    check("rst_seg",   32'(seg_o),       32'h7F);
    check("rst_idx",   32'(digit_idx_o), 32'd0);
    check("rst_step",  32'(step_en_o),   32'd0);
    check("rst_dp",    32'(dp_o),        32'd1);
    @(negedge clk_10Mhz_i);
    @(negedge clk_10Mhz_i);
    rst_i   = 1'b0;
    t       = 0;
    n       = 0;
    step_m  = 1'b0;
    frame_m = 32'h0;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    t = 0; n = 0; step_m = 1'b0; frame_m = 32'h0;
    @(negedge clk_10Mhz_i);

    // Full-frame decode with the word held, then the wrap back to digit 0.
    data_i = 32'hEBEBE1AD;
    do_reset();
    run(FRAME + 8);

    // Frame latch: a change during slot 3 stays hidden until the next frame.
    data_i = 32'h0000000D;
    do_reset();
    run(3 * SCAN_DIV + 3);
    data_i = 32'h000000AD;
    run(2 * FRAME);

    // Pause for three cycles once step_cnt reaches 2.
    do_reset();
    run(2);
    pause_i = 1'b1;
    run(3);
    pause_i = 1'b0;
    run(16);

    // Pause held for two full frames. The scan keeps running and no step pulses occur.
    pause_i = 1'b1;
    run(2 * FRAME);
    pause_i = 1'b0;
    run(10);

    // Randomized data and pause activity.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) data_i = $urandom;
      if ($urandom_range(0, 7) == 0) pause_i = ~pause_i;
      tick();
    end
    pause_i = 1'b0;

    // Async reset in the middle of the lit part of digit 5.
    data_i = $urandom;
    do_reset();
    run(5 * SCAN_DIV + 4);
    check("mid5_idx", 32'(digit_idx_o), 32'd5);
    do_reset();
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
